cos_share_sched: RTL and testbench

- Schedules one shared combinational cos lookup ROM among NREQ requesters.
- Each accepted request returns the complex pair r = cos(a), i = sin(a) = cos(90° − a), using two sequential ROM accesses.
- Sits between several phase sources (NCO channels, mixers) and the single cos ROM instance, replacing per-channel ROM copies.
- Round-robin arbitration; valid/ready on both sides.

---
 rtl/cos_share_sched_pkg.sv | 16 +
 rtl/cos_share_sched_if.sv | 30 +++
 rtl/cos_share_sched_rr_arb.sv | 32 +++
 rtl/cos_share_sched.sv | 104 ++++++++++
 tb/tb_cos_share_sched.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cos_share_sched_pkg.sv
// Shared types and constants for the cos ROM sharing scheduler.
package cos_sched_pkg;

  localparam int unsigned ANGLE_W = 12;
  localparam int unsigned DATA_W  = 16;

  localparam logic [ANGLE_W-1:0] QUARTER_TURN = 12'h400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COS  = 2'd1,
    SIN  = 2'd2,
    RESP = 2'd3
  } sched_state_t;

endpackage

// File: rtl/cos_share_sched_if.sv
// Request/response bus between the phase sources, the scheduler and the result consumer.
interface cos_share_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
);
  import cos_sched_pkg::*;

  logic [NREQ-1:0]         req_valid;
  logic [ANGLE_W*NREQ-1:0] req_angle;
  logic [NREQ-1:0]         req_ready;

  logic                    res_valid;
  logic                    res_ready;
  logic [ID_W-1:0]         res_id;
  logic [DATA_W-1:0]       res_r;
  logic [DATA_W-1:0]       res_i;

  // Requesters and result consumer.
  modport master (
    output req_valid, req_angle, res_ready,
    input  req_ready, res_valid, res_id, res_r, res_i
  );

  // The scheduler.
  modport slave (
    input  req_valid, req_angle, res_ready,
    output req_ready, res_valid, res_id, res_r, res_i
  );

endinterface

// File: rtl/cos_share_sched_rr_arb.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
module rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  int unsigned pos;

  // Scan NREQ slots starting at ptr; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    pos     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        gnt_idx  = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/cos_share_sched.sv
// Shares one combinational cos ROM among NREQ requesters; each request yields
// cos(a) then sin(a) = cos(quarter turn - a) from two consecutive ROM reads.
module cos_share_sched
  import cos_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  cos_share_sched_if.slave    bus,
  output logic [ANGLE_W-1:0]  rom_angle,
  input  logic [DATA_W-1:0]   rom_result
);

  sched_state_t       state, nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ANGLE_W-1:0] ang_q;
  logic [ID_W-1:0]    id_q;
  logic [ANGLE_W-1:0] sel_angle;
  logic [NREQ-1:0]    gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               any;

  rr_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // One-hot mux of the winning requester's angle.
  always_comb begin
    sel_angle = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_angle = bus.req_angle[i*ANGLE_W +: ANGLE_W];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state and grant; grants are only offered in IDLE and never during reset.
  always_comb begin
    nxt           = state;
    bus.req_ready = '0;
    case (state)
      IDLE: begin
        if (!rst) bus.req_ready = gnt;
        if (any)  nxt = COS;
      end
      COS:  nxt = SIN;
      SIN:  nxt = RESP;
      RESP: if (bus.res_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: capture on grant, two ROM reads, then hold the result until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= '0;
      ang_q         <= '0;
      id_q          <= '0;
      rom_angle     <= '0;
      bus.res_valid <= 1'b0;
      bus.res_id    <= '0;
      bus.res_r     <= '0;
      bus.res_i     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            ang_q     <= sel_angle;
            id_q      <= gnt_idx;
            rom_angle <= sel_angle;
            rr_ptr    <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          end
        end
        COS: begin
          bus.res_r <= rom_result;
          rom_angle <= QUARTER_TURN - ang_q;
        end
        SIN: begin
          bus.res_i     <= rom_result;
          bus.res_id    <= id_q;
          bus.res_valid <= 1'b1;
        end
        RESP: begin
          if (bus.res_ready) bus.res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cos_share_sched.sv
// Directed bench for cos_share_sched; ROM model returns {4'h0, rom_angle}.
module tb_cos_share_sched;
  import cos_sched_pkg::*;

  logic               clk;
  logic               rst;
  logic [ANGLE_W-1:0] rom_angle;
  logic [DATA_W-1:0]  rom_result;
  int                 tests;
  int                 fails;

  cos_share_sched_if #(.NREQ(4), .ID_W(2)) bus ();

  cos_share_sched #(
    .NREQ (4),
    .ID_W (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rom_angle  (rom_angle),
    .rom_result (rom_result)
  );

  assign rom_result = {4'h0, rom_angle};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_angle(input int k, input logic [11:0] a);
    bus.req_angle[k*12 +: 12] = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (bus.req_ready !== 4'b0000) begin
      fails++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
    end
    tests++;
    if (bus.res_valid !== 1'b0 || rom_angle !== 12'h000 || bus.res_id !== 2'd0 ||
        bus.res_r !== 16'h0000 || bus.res_i !== 16'h0000) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b rom=%h id=%0d r=%h i=%h want all zero",
               bus.res_valid, rom_angle, bus.res_id, bus.res_r, bus.res_i);
    end
    bus.req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.res_ready = 1'b1;
    set_angle(0, 12'h100);
    bus.req_valid = 4'b0001;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0001) begin
      fails++; $display("FAIL single_grant: got %b want 0001", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    tests++;
    if (rom_angle !== 12'h100 || bus.res_valid !== 1'b0) begin
      fails++; $display("FAIL single_cos_addr: got rom=%h v=%b want 100 0", rom_angle, bus.res_valid);
    end
    @(negedge clk);
    tests++;
    if (rom_angle !== 12'h300 || bus.res_r !== 16'h0100 || bus.res_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_sin_addr: got rom=%h r=%h v=%b want 300 0100 0", rom_angle, bus.res_r, bus.res_valid);
    end
    @(negedge clk);
    tests++;
    if (bus.res_valid !== 1'b1 || bus.res_r !== 16'h0100 || bus.res_i !== 16'h0300 || bus.res_id !== 2'd0) begin
      fails++;
      $display("FAIL single_result: got v=%b r=%h i=%h id=%0d want 1 0100 0300 0",
               bus.res_valid, bus.res_r, bus.res_i, bus.res_id);
    end
    @(negedge clk);
    tests++;
    if (bus.res_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      fails++; $display("FAIL single_idle: got v=%b rdy=%b want 0 0000", bus.res_valid, bus.req_ready);
    end
  endtask

  task automatic test_wrap();
    // rr_ptr is 1 here; requester 1 angle 0x500
    @(negedge clk);
    set_angle(1, 12'h500);
    bus.req_valid = 4'b0010;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0010) begin
      fails++; $display("FAIL wrap_grant: got %b want 0010", bus.req_ready);
    end
    repeat (2) @(negedge clk);
    bus.req_valid = '0;
    tests++;
    if (rom_angle !== 12'hF00) begin
      fails++; $display("FAIL wrap_addr: got %h want f00", rom_angle);
    end
    @(negedge clk);
    tests++;
    if (bus.res_valid !== 1'b1 || bus.res_r !== 16'h0500 || bus.res_i !== 16'h0F00 || bus.res_id !== 2'd1) begin
      fails++;
      $display("FAIL wrap_result: got v=%b r=%h i=%h id=%0d want 1 0500 0f00 1",
               bus.res_valid, bus.res_r, bus.res_i, bus.res_id);
    end
    // quarter turn exactly: sin address wraps to 0
    @(negedge clk);
    set_angle(2, 12'h400);
    bus.req_valid = 4'b0100;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0100) begin
      fails++; $display("FAIL wrap400_grant: got %b want 0100", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    tests++;
    if (rom_angle !== 12'h000) begin
      fails++; $display("FAIL wrap400_addr: got %h want 000", rom_angle);
    end
    @(negedge clk);
    tests++;
    if (bus.res_valid !== 1'b1 || bus.res_r !== 16'h0400 || bus.res_i !== 16'h0000 || bus.res_id !== 2'd2) begin
      fails++;
      $display("FAIL wrap400_result: got v=%b r=%h i=%h id=%0d want 1 0400 0000 2",
               bus.res_valid, bus.res_r, bus.res_i, bus.res_id);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_gnt;
    logic [15:0] exp_r;
    logic [15:0] exp_i;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_angle(0, 12'h010);
    set_angle(1, 12'h020);
    set_angle(2, 12'h030);
    set_angle(3, 12'h040);
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_gnt = 4'b0001 << (k % 4);
      exp_r   = 16'h0010 * 16'((k % 4) + 1);
      exp_i   = 16'h0400 - exp_r;
      tests++;
      if (bus.req_ready !== exp_gnt) begin
        fails++; $display("FAIL rr_grant_%0d: got %b want %b", k, bus.req_ready, exp_gnt);
      end
      repeat (3) @(negedge clk);
      tests++;
      if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(k % 4) || bus.res_r !== exp_r || bus.res_i !== exp_i) begin
        fails++;
        $display("FAIL rr_result_%0d: got v=%b id=%0d r=%h i=%h want 1 %0d %h %h",
                 k, bus.res_valid, bus.res_id, bus.res_r, bus.res_i, k % 4, exp_r, exp_i);
      end
      if (k == 4) bus.req_valid = '0;
      else        @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    // rr_ptr is 1 here
    @(negedge clk);
    bus.res_ready = 1'b0;
    set_angle(1, 12'h123);
    set_angle(3, 12'h7FF);
    bus.req_valid = 4'b1010;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0010) begin
      fails++; $display("FAIL bp_grant: got %b want 0010", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 4'b1000;
    #1;
    for (int c = 0; c < 2; c++) begin
      tests++;
      if (bus.req_ready !== 4'b0000 || bus.res_valid !== 1'b0) begin
        fails++; $display("FAIL bp_busy_%0d: got rdy=%b v=%b want 0000 0", c, bus.req_ready, bus.res_valid);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd1 || bus.res_r !== 16'h0123 ||
          bus.res_i !== 16'h02DD || bus.req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL bp_hold_%0d: got v=%b id=%0d r=%h i=%h rdy=%b want 1 1 0123 02dd 0000",
                 c, bus.res_valid, bus.res_id, bus.res_r, bus.res_i, bus.req_ready);
      end
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    #1;
    tests++;
    if (bus.res_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin
      fails++; $display("FAIL bp_handshake: got v=%b rdy=%b want 1 0000", bus.res_valid, bus.req_ready);
    end
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 4'b1000 || bus.res_valid !== 1'b0) begin
      fails++; $display("FAIL bp_next_grant: got rdy=%b v=%b want 1000 0", bus.req_ready, bus.res_valid);
    end
    @(negedge clk);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd3 || bus.res_r !== 16'h07FF || bus.res_i !== 16'h0C01) begin
      fails++;
      $display("FAIL bp_second: got v=%b id=%0d r=%h i=%h want 1 3 07ff 0c01",
               bus.res_valid, bus.res_id, bus.res_r, bus.res_i);
    end
  endtask

  task automatic test_reset_mid();
    // rr_ptr is 0 here; requester 2 wins
    @(negedge clk);
    set_angle(1, 12'h100);
    set_angle(2, 12'h222);
    bus.req_valid = 4'b0100;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0100) begin
      fails++; $display("FAIL rmid_grant: got %b want 0100", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.res_valid !== 1'b0 || rom_angle !== 12'h000 || bus.req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL rmid_cleared: got v=%b rom=%h rdy=%b want 0 000 0000", bus.res_valid, rom_angle, bus.req_ready);
    end
    rst = 1'b0;
    bus.req_valid = 4'b0110;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0010) begin
      fails++; $display("FAIL rmid_ptr: got %b want 0010", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    tests++;
    if (bus.res_valid !== 1'b0 || rom_angle !== 12'h100) begin
      fails++; $display("FAIL rmid_addr: got v=%b rom=%h want 0 100", bus.res_valid, rom_angle);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd1 || bus.res_r !== 16'h0100 || bus.res_i !== 16'h0300) begin
      fails++;
      $display("FAIL rmid_result: got v=%b id=%0d r=%h i=%h want 1 1 0100 0300",
               bus.res_valid, bus.res_id, bus.res_r, bus.res_i);
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if (bus.req_ready !== 4'b0000 || rom_angle !== 12'h300 || bus.res_valid !== 1'b0) begin
        fails++;
        $display("FAIL idle_%0d: got rdy=%b rom=%h v=%b want 0000 300 0", c, bus.req_ready, rom_angle, bus.res_valid);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_angle = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
